// File: rtl/fold_frame_sequencer.sv
// rtl/fold_frame_sequencer.sv - scheduler for a single-token fold actor with per-frame output emission
// Optional FOLD/OUT watchdog enabled by defining FOLD_SEQ_WATCHDOG_EN.
module fold_frame_sequencer #(
    parameter int FRAME_LEN_DEFAULT = 262144,
    parameter int CNT_W             = 32,
    parameter int WDOG_CYCLES       = 1024
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             cfg_len_wr,
    input  logic [CNT_W-1:0] cfg_len,
    output logic             cfg_reject,
    input  logic             In_SEND,
    output logic             In_ACK,
    input  logic             Out_RDY,
    output logic             fold_go,
    input  logic             fold_done,
    output logic             out_go,
    input  logic             out_done,
    output logic             clear_state,
    output logic [CNT_W-1:0] token_count,
    output logic [15:0]      frame_count,
    output logic             busy,
    output logic             wdog_err
);

    typedef enum logic [1:0] {S_IDLE, S_FOLD, S_EMIT, S_OUT} state_t;

    state_t           r_state;
    logic             r_started;
    logic [CNT_W-1:0] r_frame_len;
    logic [CNT_W-1:0] r_token_count;
    logic [15:0]      r_frame_count;
    logic             r_cfg_reject;

    logic w_accept;
    logic w_emit;
    logic w_out_fin;
    logic w_cfg_ok;
    logic w_timeout;

    assign w_accept  = r_started && (r_state == S_IDLE) && In_SEND && (r_token_count < r_frame_len);
    assign w_emit    = r_started && (r_state == S_EMIT) && Out_RDY;
    assign w_out_fin = (r_state == S_OUT) && out_done;
    // Length may only change between frames, before the first token is taken.
    assign w_cfg_ok  = (r_state == S_IDLE) && (r_token_count == '0) && (cfg_len != '0);

`ifdef FOLD_SEQ_WATCHDOG_EN
    logic [31:0] r_wdog_cnt;
    logic        r_wdog_err;
    logic        w_wdog_wait;

    assign w_wdog_wait = ((r_state == S_FOLD) && !fold_done) || ((r_state == S_OUT) && !out_done);
    assign w_timeout   = w_wdog_wait && (r_wdog_cnt == 32'(WDOG_CYCLES - 1));
    assign wdog_err    = r_wdog_err;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_cnt <= (w_wdog_wait && !w_timeout) ? r_wdog_cnt + 32'd1 : '0;
            if (w_timeout)
                r_wdog_err <= 1'b1;
        end
    end
`else
    logic w_unused_wdog;
    assign w_unused_wdog = ^WDOG_CYCLES;
    assign w_timeout     = 1'b0;
    assign wdog_err      = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_started     <= 1'b0;
            r_frame_len   <= CNT_W'(FRAME_LEN_DEFAULT);
            r_token_count <= '0;
            r_frame_count <= '0;
            r_cfg_reject  <= 1'b0;
        end else begin
            r_started    <= 1'b1;
            r_cfg_reject <= cfg_len_wr && !w_cfg_ok;
            if (cfg_len_wr && w_cfg_ok)
                r_frame_len <= cfg_len;
            case (r_state)
                S_IDLE: begin
                    if (w_accept)
                        r_state <= S_FOLD;
                    else if (r_started && (r_token_count == r_frame_len))
                        r_state <= S_EMIT;
                end
                S_FOLD: begin
                    if (w_timeout) begin
                        r_token_count <= '0;
                        r_state       <= S_IDLE;
                    end else if (fold_done) begin
                        r_token_count <= r_token_count + 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                S_EMIT: begin
                    if (w_emit)
                        r_state <= S_OUT;
                end
                S_OUT: begin
                    // A timed-out output abandons the frame without counting it.
                    if (w_timeout) begin
                        r_token_count <= '0;
                        r_state       <= S_IDLE;
                    end else if (out_done) begin
                        r_token_count <= '0;
                        r_frame_count <= r_frame_count + 16'd1;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fold_go     = w_accept;
    assign In_ACK      = w_accept;
    assign out_go      = w_emit;
    assign clear_state = w_out_fin || w_timeout;
    assign cfg_reject  = r_cfg_reject;
    assign token_count = r_token_count;
    assign frame_count = r_frame_count;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_fold_frame_sequencer.sv
// tb/tb_fold_frame_sequencer.sv - self-checking bench for fold_frame_sequencer
// Define FOLD_SEQ_WATCHDOG_EN to also exercise the watchdog scenario.
module tb_fold_frame_sequencer;

    localparam int CNT_W = 32;
    localparam int FLEN  = 5;
    localparam int WDOG  = 16;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             cfg_len_wr = 1'b0;
    logic [CNT_W-1:0] cfg_len = '0;
    logic             cfg_reject;
    logic             In_SEND = 1'b0;
    logic             In_ACK;
    logic             Out_RDY = 1'b0;
    logic             fold_go;
    logic             fold_done = 1'b0;
    logic             out_go;
    logic             out_done = 1'b0;
    logic             clear_state;
    logic [CNT_W-1:0] token_count;
    logic [15:0]      frame_count;
    logic             busy;
    logic             wdog_err;

    int errors = 0;
    int checks = 0;

    fold_frame_sequencer #(
        .FRAME_LEN_DEFAULT(FLEN),
        .CNT_W(CNT_W),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .cfg_len_wr(cfg_len_wr), .cfg_len(cfg_len), .cfg_reject(cfg_reject),
        .In_SEND(In_SEND), .In_ACK(In_ACK), .Out_RDY(Out_RDY),
        .fold_go(fold_go), .fold_done(fold_done),
        .out_go(out_go), .out_done(out_done),
        .clear_state(clear_state), .token_count(token_count),
        .frame_count(frame_count), .busy(busy), .wdog_err(wdog_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Presents one token at a time, answers each fold_go with fold_done one cycle later.
    task automatic feed_tokens(input int n, output int got);
        got = 0;
        for (int t = 0; t < n; t++) begin
            bit seen;
            seen = 1'b0;
            In_SEND = 1'b1;
            for (int b = 0; b < 20 && !seen; b++) begin
                @(negedge CLK);
                seen = fold_go;
                tick;
            end
            In_SEND = 1'b0;
            if (!seen) break;
            got++;
            fold_done = 1'b1;
            tick;
            fold_done = 1'b0;
        end
    endtask

    task automatic finish_frame(output bit og, output bit cs);
        og = 1'b0;
        cs = 1'b0;
        Out_RDY = 1'b1;
        for (int b = 0; b < 20 && !og; b++) begin
            @(negedge CLK);
            og = out_go;
            tick;
        end
        Out_RDY = 1'b0;
        if (og) begin
            out_done = 1'b1;
            @(negedge CLK);
            cs = clear_state;
            tick;
            out_done = 1'b0;
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1; In_SEND = 1'b1; Out_RDY = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({fold_go, In_ACK, out_go, clear_state, cfg_reject, busy, wdog_err} !== 7'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 0000000",
                {fold_go, In_ACK, out_go, clear_state, cfg_reject, busy, wdog_err});
        end
        checks++;
        if (token_count !== 0 || frame_count !== 0) begin
            errors++; $display("FAIL reset_counts: got tc=%0d fc=%0d expected 0/0", token_count, frame_count);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (fold_go !== 1'b0) begin
            errors++; $display("FAIL start_gate: got fold_go=%b expected 0 before start flag", fold_go);
        end
        tick;
        @(negedge CLK);
        checks++;
        if (fold_go !== 1'b1 || In_ACK !== 1'b1) begin
            errors++; $display("FAIL first_accept: got fold_go=%b In_ACK=%b expected 1/1", fold_go, In_ACK);
        end
        #1;
        RESET = 1'b1; In_SEND = 1'b0; Out_RDY = 1'b0;
        tick;
        RESET = 1'b0;
        tick;
    endtask

    task automatic test_basic_frame;
        int nf, na, no, nc, last, gap_bad;
        bit fd_n, od_n, done;
        cfg_len_wr = 1'b1; cfg_len = 4;
        tick;
        cfg_len_wr = 1'b0;
        @(negedge CLK);
        checks++;
        if (cfg_reject !== 1'b0) begin
            errors++; $display("FAIL cfg4_accept: got cfg_reject=%b expected 0", cfg_reject);
        end
        tick;
        nf = 0; na = 0; no = 0; nc = 0; last = -1; gap_bad = 0; fd_n = 0; od_n = 0; done = 0;
        In_SEND = 1'b1; Out_RDY = 1'b1;
        for (int c = 0; c < 80 && !done; c++) begin
            fold_done = fd_n; out_done = od_n;
            @(negedge CLK);
            if (fold_go) begin
                nf++;
                if (last >= 0 && c - last != 2) gap_bad++;
                last = c;
            end
            na += int'(In_ACK); no += int'(out_go); nc += int'(clear_state);
            fd_n = fold_go; od_n = out_go;
            if (clear_state) begin done = 1; In_SEND = 1'b0; Out_RDY = 1'b0; end
            tick;
        end
        fold_done = 1'b0; out_done = 1'b0; In_SEND = 1'b0; Out_RDY = 1'b0;
        checks++;
        if (nf !== 4 || na !== 4) begin
            errors++; $display("FAIL basic_folds: got fold_go=%0d In_ACK=%0d expected 4/4", nf, na);
        end
        checks++;
        if (no !== 1 || nc !== 1 || !done) begin
            errors++; $display("FAIL basic_emit: got out_go=%0d clear=%0d expected 1/1", no, nc);
        end
        checks++;
        if (gap_bad !== 0) begin
            errors++; $display("FAIL basic_throughput: got %0d gaps != 2 cycles expected 0", gap_bad);
        end
        @(negedge CLK);
        checks++;
        if (token_count !== 0 || frame_count !== 1) begin
            errors++; $display("FAIL basic_end: got tc=%0d fc=%0d expected 0/1", token_count, frame_count);
        end
        tick;
    endtask

    task automatic test_backpressure;
        int got, bad;
        cfg_len_wr = 1'b1; cfg_len = 3;
        tick;
        cfg_len_wr = 1'b0;
        feed_tokens(3, got);
        checks++;
        if (got !== 3) begin
            errors++; $display("FAIL bp_feed: got %0d tokens expected 3", got);
        end
        In_SEND = 1'b1; Out_RDY = 1'b0;
        tick;
        bad = 0;
        repeat (10) begin
            @(negedge CLK);
            if (busy !== 1'b1 || out_go !== 1'b0 || In_ACK !== 1'b0 || token_count !== 3) bad++;
            tick;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL bp_hold: got %0d bad EMIT cycles expected 0", bad);
        end
        Out_RDY = 1'b1;
        @(negedge CLK);
        checks++;
        if (out_go !== 1'b1) begin
            errors++; $display("FAIL bp_release: got out_go=%b expected 1", out_go);
        end
        tick;
        Out_RDY = 1'b0; In_SEND = 1'b0; out_done = 1'b1;
        @(negedge CLK);
        checks++;
        if (clear_state !== 1'b1) begin
            errors++; $display("FAIL bp_clear: got clear_state=%b expected 1", clear_state);
        end
        tick;
        out_done = 1'b0;
        @(negedge CLK);
        checks++;
        if (frame_count !== 2 || token_count !== 0) begin
            errors++; $display("FAIL bp_end: got fc=%0d tc=%0d expected 2/0", frame_count, token_count);
        end
        tick;
    endtask

    task automatic test_cfg_reject;
        int got;
        bit og, cs;
        cfg_len_wr = 1'b1; cfg_len = 4;
        tick;
        cfg_len_wr = 1'b0;
        feed_tokens(2, got);
        cfg_len_wr = 1'b1; cfg_len = 8;
        tick;
        cfg_len_wr = 1'b0;
        @(negedge CLK);
        checks++;
        if (cfg_reject !== 1'b1) begin
            errors++; $display("FAIL cfg_mid_reject: got cfg_reject=%b expected 1", cfg_reject);
        end
        tick;
        @(negedge CLK);
        checks++;
        if (cfg_reject !== 1'b0) begin
            errors++; $display("FAIL cfg_reject_once: got cfg_reject=%b expected 0", cfg_reject);
        end
        tick;
        feed_tokens(2, got);
        finish_frame(og, cs);
        checks++;
        if (!og || !cs || frame_count !== 3) begin
            errors++; $display("FAIL cfg_len_kept4: got out_go=%b clear=%b fc=%0d expected 1/1/3", og, cs, frame_count);
        end
        cfg_len_wr = 1'b1; cfg_len = 2; In_SEND = 1'b1;
        @(negedge CLK);
        checks++;
        if (In_ACK !== 1'b1) begin
            errors++; $display("FAIL cfg_coincident_ack: got In_ACK=%b expected 1", In_ACK);
        end
        tick;
        cfg_len_wr = 1'b0; In_SEND = 1'b0; fold_done = 1'b1;
        @(negedge CLK);
        checks++;
        if (cfg_reject !== 1'b0) begin
            errors++; $display("FAIL cfg_coincident_accept: got cfg_reject=%b expected 0", cfg_reject);
        end
        tick;
        fold_done = 1'b0;
        feed_tokens(1, got);
        finish_frame(og, cs);
        checks++;
        if (!og || !cs || frame_count !== 4) begin
            errors++; $display("FAIL cfg_len2_frame: got out_go=%b clear=%b fc=%0d expected 1/1/4", og, cs, frame_count);
        end
        cfg_len_wr = 1'b1; cfg_len = 0;
        tick;
        cfg_len_wr = 1'b0;
        @(negedge CLK);
        checks++;
        if (cfg_reject !== 1'b1) begin
            errors++; $display("FAIL cfg_zero_reject: got cfg_reject=%b expected 1", cfg_reject);
        end
        tick;
    endtask

    task automatic test_reset_mid_fold;
        int got, nog;
        bit og, cs;
        feed_tokens(2, got);
        In_SEND = 1'b1;
        @(negedge CLK);
        tick;
        In_SEND = 1'b0;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b1 || token_count !== 2) begin
            errors++; $display("FAIL rst_pre_fold: got busy=%b tc=%0d expected 1/2", busy, token_count);
        end
        #1 RESET = 1'b1;
        #1;
        checks++;
        if ({fold_go, In_ACK, out_go, clear_state, cfg_reject, busy, wdog_err} !== 7'b0
            || token_count !== 0 || frame_count !== 0) begin
            errors++; $display("FAIL rst_async: got flags=%b tc=%0d fc=%0d expected all 0",
                {fold_go, In_ACK, out_go, clear_state, cfg_reject, busy, wdog_err}, token_count, frame_count);
        end
        tick;
        RESET = 1'b0;
        tick;
        feed_tokens(4, got);
        nog = 0;
        Out_RDY = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            nog += int'(out_go);
            tick;
        end
        Out_RDY = 1'b0;
        checks++;
        if (got !== 4 || nog !== 0) begin
            errors++; $display("FAIL rst_default_len: got tokens=%0d early out_go=%0d expected 4/0", got, nog);
        end
        feed_tokens(1, got);
        finish_frame(og, cs);
        checks++;
        if (!og || !cs || frame_count !== 1) begin
            errors++; $display("FAIL rst_frame5: got out_go=%b clear=%b fc=%0d expected 1/1/1", og, cs, frame_count);
        end
    endtask

    task automatic test_spurious_done;
        int got, bad;
        bit og, cs;
        feed_tokens(1, got);
        fold_done = 1'b1; out_done = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge CLK);
            if (token_count !== 1 || busy !== 1'b0 || clear_state !== 1'b0 || fold_go !== 1'b0) bad++;
            tick;
        end
        fold_done = 1'b0; out_done = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL spurious_idle: got %0d bad cycles expected 0", bad);
        end
        feed_tokens(4, got);
        tick;
        fold_done = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge CLK);
            if (token_count !== 5 || busy !== 1'b1 || out_go !== 1'b0) bad++;
            tick;
        end
        fold_done = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL spurious_emit: got %0d bad cycles expected 0", bad);
        end
        finish_frame(og, cs);
        checks++;
        if (!og || !cs || frame_count !== 2 || token_count !== 0) begin
            errors++; $display("FAIL spurious_end: got out_go=%b clear=%b fc=%0d tc=%0d expected 1/1/2/0",
                og, cs, frame_count, token_count);
        end
    endtask

    // Transaction-level model: tokens folded so far, outstanding fold/output requests, frame length.
    task automatic test_random;
        int m_len, m_cnt, m_frames, m_age, f_lat, o_lat;
        bit fold_out, out_out, exp_rej, e_fg, e_og, e_cs, e_busy, acc;
        RESET = 1'b1; In_SEND = 1'b0; Out_RDY = 1'b0; fold_done = 1'b0; out_done = 1'b0; cfg_len_wr = 1'b0;
        tick; tick;
        RESET = 1'b0;
        tick;
        m_len = FLEN; m_cnt = 0; m_frames = 0; m_age = 0; f_lat = 0; o_lat = 0;
        fold_out = 0; out_out = 0; exp_rej = 0;
        for (int c = 0; c < 1500; c++) begin
            In_SEND    = ($urandom_range(99) < 60);
            Out_RDY    = ($urandom_range(99) < 50);
            fold_done  = fold_out ? (f_lat == 0) : ($urandom_range(99) < 10);
            out_done   = out_out ? (o_lat == 0) : ($urandom_range(99) < 10);
            cfg_len_wr = ($urandom_range(99) < 8);
            cfg_len    = $urandom_range(6);
            @(negedge CLK);
            e_fg   = In_SEND && !fold_out && (m_cnt < m_len);
            e_og   = Out_RDY && !out_out && (m_cnt == m_len) && (m_age >= 1);
            e_cs   = out_out && out_done;
            e_busy = fold_out || out_out || ((m_cnt == m_len) && (m_age >= 1));
            checks++;
            if (fold_go !== e_fg || In_ACK !== e_fg) begin
                errors++; $display("FAIL rnd_accept c=%0d: got fold_go=%b In_ACK=%b expected %b", c, fold_go, In_ACK, e_fg);
            end
            checks++;
            if (out_go !== e_og) begin
                errors++; $display("FAIL rnd_out_go c=%0d: got %b expected %b", c, out_go, e_og);
            end
            checks++;
            if (clear_state !== e_cs) begin
                errors++; $display("FAIL rnd_clear c=%0d: got %b expected %b", c, clear_state, e_cs);
            end
            checks++;
            if (busy !== e_busy || wdog_err !== 1'b0) begin
                errors++; $display("FAIL rnd_busy c=%0d: got busy=%b wdog=%b expected %b/0", c, busy, wdog_err, e_busy);
            end
            checks++;
            if (token_count !== CNT_W'(m_cnt) || frame_count !== 16'(m_frames)) begin
                errors++; $display("FAIL rnd_counts c=%0d: got tc=%0d fc=%0d expected %0d/%0d",
                    c, token_count, frame_count, m_cnt, m_frames);
            end
            checks++;
            if (cfg_reject !== exp_rej) begin
                errors++; $display("FAIL rnd_cfg_reject c=%0d: got %b expected %b", c, cfg_reject, exp_rej);
            end
            acc = cfg_len_wr && !fold_out && (m_cnt == 0) && (cfg_len != 0);
            exp_rej = cfg_len_wr && !acc;
            if (m_cnt == m_len) m_age++;
            if (fold_out && fold_done) begin
                fold_out = 0;
                m_cnt++;
                if (m_cnt == m_len) m_age = 0;
            end else if (fold_out) begin
                f_lat--;
            end
            if (e_fg) begin
                fold_out = 1;
                f_lat = $urandom_range(3);
            end
            if (out_out && out_done) begin
                out_out = 0;
                m_cnt = 0;
                m_frames++;
            end else if (out_out) begin
                o_lat--;
            end
            if (e_og) begin
                out_out = 1;
                o_lat = $urandom_range(3);
            end
            if (acc) m_len = int'(cfg_len);
            tick;
        end
        In_SEND = 1'b0; Out_RDY = 1'b0; fold_done = 1'b0; out_done = 1'b0; cfg_len_wr = 1'b0;
    endtask

`ifdef FOLD_SEQ_WATCHDOG_EN
    task automatic test_watchdog;
        int cs_at, got;
        RESET = 1'b1;
        tick; tick;
        RESET = 1'b0;
        tick;
        In_SEND = 1'b1;
        @(negedge CLK);
        checks++;
        if (fold_go !== 1'b1) begin
            errors++; $display("FAIL wd_accept: got fold_go=%b expected 1", fold_go);
        end
        tick;
        In_SEND = 1'b0;
        cs_at = -1;
        for (int c = 1; c <= 24 && cs_at < 0; c++) begin
            @(negedge CLK);
            if (clear_state) cs_at = c;
            tick;
        end
        checks++;
        if (cs_at !== WDOG) begin
            errors++; $display("FAIL wd_timeout_cycle: got %0d expected %0d", cs_at, WDOG);
        end
        @(negedge CLK);
        checks++;
        if (wdog_err !== 1'b1 || busy !== 1'b0 || token_count !== 0 || frame_count !== 0) begin
            errors++; $display("FAIL wd_after: got wdog=%b busy=%b tc=%0d fc=%0d expected 1/0/0/0",
                wdog_err, busy, token_count, frame_count);
        end
        tick;
        feed_tokens(1, got);
        @(negedge CLK);
        checks++;
        if (got !== 1 || token_count !== 1 || wdog_err !== 1'b1) begin
            errors++; $display("FAIL wd_recover: got tokens=%0d tc=%0d wdog=%b expected 1/1/1", got, token_count, wdog_err);
        end
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_basic_frame;
        test_backpressure;
        test_cfg_reject;
        test_reset_mid_fold;
        test_spurious_done;
        test_random;
`ifdef FOLD_SEQ_WATCHDOG_EN
        test_watchdog;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
